threshold_calibrator: RTL and testbench
=======================================

# threshold_calibrator

Automatic fringe-threshold calibrator for the position tracker. It passively taps the same AXI-Stream sample stream the position tracker consumes and measures the signal's min/max over a window of 2^WINDOW_LOG2 valid samples. From those it derives a symmetric hysteresis band around the signal midpoint and drives `FC_lower_treshold`/`FC_upper_treshold` into the tracker, either once per start command or continuously, with a manual override path.

## Interface
- `AXIS_TDATA_WIDTH`, 32, sample and threshold width (two's complement)
- `WINDOW_LOG2`, 10, window length = 2^WINDOW_LOG2 valid samples (1..16)
- `DEFAULT_LOWER`, -1024, lower threshold after reset
- `DEFAULT_UPPER`, 1024, upper threshold after reset

Ports:
- `SYS_aclk`  in  1  single clock; everything is rising-edge
- `SYS_aresetn`  in  1  reset, asynchronous, active-low
- `S_AXIS_tvalid`  in  1  sample valid; monitored tap, no tready/backpressure
- `S_AXIS_tdata`  in  AXIS_TDATA_WIDTH  signed sample
- `CFG_start`  in  1  start one calibration; level sampled in IDLE
- `CFG_continuous`  in  1  re-arm automatically after each APPLY
- `CFG_hyst_shift`  in  5  delta = half_span >> CFG_hyst_shift
- `CFG_min_span`  in  AXIS_TDATA_WIDTH  unsigned; minimum (max-min) for a valid result
- `CFG_manual`  in  1  1: outputs follow manual values
- `CFG_manual_lower` / `CFG_manual_upper`  in  AXIS_TDATA_WIDTH  manual thresholds
- `FC_lower_treshold` / `FC_upper_treshold`  out  AXIS_TDATA_WIDTH  thresholds to position tracker (registered)
- `CAL_busy`  out  1  high in ACQUIRE/COMPUTE/APPLY
- `CAL_done`  out  1  one-cycle pulse at end of APPLY
- `CAL_valid`  out  1  sticky: at least one successful calibration
- `CAL_error`  out  1  last calibration rejected (span too small)

## Operation
- Reset: state IDLE; FC outputs = DEFAULT_LOWER/UPPER; internal cal_lower/cal_upper = same defaults; busy/done/valid/error = 0; counter, min and max cleared.
- FSM states and transitions:
  - IDLE: enter ACQUIRE when `CFG_start | CFG_continuous`.
  - ACQUIRE: count samples with `S_AXIS_tvalid` high. The first sample loads min = max = tdata; later samples update min/max (signed compare). After the 2^WINDOW_LOG2-th sample, go to COMPUTE.
  - COMPUTE: span = max - min (W+1 bits, unsigned); mid = (min + max) >>> 1 (W+1-bit sum, arithmetic shift); half = span >> 1; delta = half >> CFG_hyst_shift. All registered. Go to APPLY.
  - APPLY:
    - If span ≥ CFG_min_span: cal_lower = mid - delta, cal_upper = mid + delta, CAL_valid = 1, CAL_error = 0.
    - Else: cal regs unchanged, CAL_error = 1.
    - Pulse CAL_done. Go to ACQUIRE if `CFG_continuous`, else IDLE.
- Invariant: min ≤ cal_lower ≤ cal_upper ≤ max. No overflow is possible, so no saturation logic.
- Output mux (registered every cycle): FC = CFG_manual ? manual inputs : cal regs. Lower and upper always change on the same edge, never split.
- Calibration runs regardless of CFG_manual; results become visible when manual drops.
- CFG_start while busy is ignored. Clearing CFG_continuous mid-window finishes the current window, then goes to IDLE.
- CFG_hyst_shift and CFG_min_span are sampled in COMPUTE/APPLY only.
- Async reset mid-window discards the partial window; outputs return to defaults immediately.

## Timing
- In ACQUIRE, a sample is accepted on any edge with tvalid=1. Gaps in tvalid only stretch the window.
- Let edge k accept the last window sample. Then state = COMPUTE after k, APPLY after k+1, and FC outputs, CAL_done, CAL_valid and CAL_error update at edge k+2. This is a 2-cycle result latency.
- CAL_done is high exactly one cycle, coincident with the first cycle the new thresholds are driven.
- In continuous mode, ACQUIRE re-enters after k+2. Samples at edges k+1 and k+2 are not counted, so the next window starts at edge k+3 or later.
- Manual path latency: 1 cycle from CFG_manual* change to FC outputs.
- CAL_busy rises the cycle after start is seen and falls the cycle after APPLY (non-continuous).

## Test plan
- Reset with defaults (DEFAULT_LOWER=-1024, DEFAULT_UPPER=1024) -> FC outputs = -1024/1024, busy=done=valid=error=0, both while reset is held and right after release.
- WINDOW_LOG2=3, shift=1, min_span=4, triangle 10,5,0,-5,-10,-15,15,0 with start pulse -> lower=-7, upper=7, CAL_done one cycle exactly 2 cycles after the 8th sample, valid=1.
- shift=0, samples 100..140 in steps incl. 100 and 140, tvalid toggled 50% -> lower=100, upper=140. Window counts only valid samples.
- Constant samples 5, min_span=4 -> CAL_error=1, thresholds keep previous values (-7/7), CAL_valid stays 1.
- CFG_manual=1 with manual -3/3 during a calibration -> FC = -3/3 one cycle after assertion. Drop manual after done -> FC = calibrated values one cycle later.
- Continuous mode with reset asserted mid-window, plus a start pulse while busy -> FC returns to defaults asynchronously. The start pulse while busy has no effect. Back-to-back windows produce one done pulse each.

Source files
------------

// File: rtl/threshold_calibrator.sv
// Fringe-threshold calibrator: measures min/max of the tapped sample stream over a window and
// derives a symmetric hysteresis band around the midpoint, with a manual override path.
module threshold_calibrator #(
  parameter int          AXIS_TDATA_WIDTH = 32,
  parameter int unsigned WINDOW_LOG2      = 10,
  parameter int          DEFAULT_LOWER    = -1024,
  parameter int          DEFAULT_UPPER    = 1024
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        CFG_start,
  input  logic                        CFG_continuous,
  input  logic [4:0]                  CFG_hyst_shift,
  input  logic [AXIS_TDATA_WIDTH-1:0] CFG_min_span,
  input  logic                        CFG_manual,
  input  logic [AXIS_TDATA_WIDTH-1:0] CFG_manual_lower,
  input  logic [AXIS_TDATA_WIDTH-1:0] CFG_manual_upper,
  output logic [AXIS_TDATA_WIDTH-1:0] FC_lower_treshold,
  output logic [AXIS_TDATA_WIDTH-1:0] FC_upper_treshold,
  output logic                        CAL_busy,
  output logic                        CAL_done,
  output logic                        CAL_valid,
  output logic                        CAL_error
);

  localparam int W = AXIS_TDATA_WIDTH;
  localparam logic [W-1:0] DefLower = W'(DEFAULT_LOWER);
  localparam logic [W-1:0] DefUpper = W'(DEFAULT_UPPER);

  typedef enum logic [1:0] {StIdle, StAcquire, StCompute, StApply} state_e;

  state_e state_q, state_d;
  logic   acc_en, comp_en, apply_en;

  logic        [WINDOW_LOG2-1:0] cnt_q;
  logic signed [W-1:0]           min_q, max_q, mid_q, mid_d;
  logic        [W:0]             span_q, span_d;
  logic signed [W:0]             sum_d;
  logic        [W-1:0]           half_d, delta_q, delta_d;
  logic        [W-1:0]           cal_lower_q, cal_lower_d, cal_upper_q, cal_upper_d;
  logic        [W-1:0]           fc_lower_q, fc_upper_q;
  logic                          valid_q, valid_d, error_q, error_d, done_q;
  logic signed [W-1:0]           sample;

  assign sample = $signed(S_AXIS_tdata);

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) state_q <= StIdle;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (CFG_start || CFG_continuous) state_d = StAcquire;
      StAcquire: if (S_AXIS_tvalid && (&cnt_q)) state_d = StCompute;
      StCompute: state_d = StApply;
      StApply:   state_d = CFG_continuous ? StAcquire : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    CAL_busy = (state_q != StIdle);
    acc_en   = (state_q == StAcquire) && S_AXIS_tvalid;
    comp_en  = (state_q == StCompute);
    apply_en = (state_q == StApply);
  end

  // Sign-extended to W+1 bits so neither the span nor the sum can overflow.
  always_comb begin
    span_d  = {max_q[W-1], max_q} - {min_q[W-1], min_q};
    sum_d   = $signed({min_q[W-1], min_q}) + $signed({max_q[W-1], max_q});
    mid_d   = W'(sum_d >>> 1);
    half_d  = W'(span_d >> 1);
    delta_d = half_d >> CFG_hyst_shift;
  end

  always_comb begin
    cal_lower_d = cal_lower_q;
    cal_upper_d = cal_upper_q;
    valid_d     = valid_q;
    error_d     = error_q;
    if (apply_en) begin
      if (span_q >= {1'b0, CFG_min_span}) begin
        cal_lower_d = mid_q - delta_q;
        cal_upper_d = mid_q + delta_q;
        valid_d     = 1'b1;
        error_d     = 1'b0;
      end else begin
        error_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      span_q      <= '0;
      mid_q       <= '0;
      delta_q     <= '0;
      cal_lower_q <= DefLower;
      cal_upper_q <= DefUpper;
      fc_lower_q  <= DefLower;
      fc_upper_q  <= DefUpper;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (acc_en) begin
        cnt_q <= cnt_q + WINDOW_LOG2'(1);
        if (cnt_q == '0) begin
          min_q <= sample;
          max_q <= sample;
        end else begin
          if (sample < min_q) min_q <= sample;
          if (sample > max_q) max_q <= sample;
        end
      end
      if (comp_en) begin
        span_q  <= span_d;
        mid_q   <= mid_d;
        delta_q <= delta_d;
      end
      cal_lower_q <= cal_lower_d;
      cal_upper_q <= cal_upper_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      done_q      <= apply_en;
      // Mux from next-state cal values so results appear on the same edge as CAL_done.
      fc_lower_q  <= CFG_manual ? CFG_manual_lower : cal_lower_d;
      fc_upper_q  <= CFG_manual ? CFG_manual_upper : cal_upper_d;
    end
  end

  assign FC_lower_treshold = fc_lower_q;
  assign FC_upper_treshold = fc_upper_q;
  assign CAL_done          = done_q;
  assign CAL_valid         = valid_q;
  assign CAL_error         = error_q;

endmodule

// File: tb/tb_threshold_calibrator.sv
// Bench for threshold_calibrator: table-driven windows, random windows against a min/max
// arithmetic model, manual override, async reset mid-window and continuous back-to-back windows.
module tb_threshold_calibrator;
  localparam int W = 32;
  localparam int N = 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                tvalid = 1'b0;
  logic signed [W-1:0] tdata = '0;
  logic                start = 1'b0, cont = 1'b0, manual = 1'b0;
  logic [4:0]          shift = '0;
  logic [W-1:0]        min_span = '0;
  logic signed [W-1:0] man_lo = '0, man_hi = '0;
  logic signed [W-1:0] fc_lo, fc_hi;
  logic                busy, done, valid, err;

  always #5 clk = ~clk;

  threshold_calibrator #(
    .AXIS_TDATA_WIDTH(W),
    .WINDOW_LOG2(3),
    .DEFAULT_LOWER(-1024),
    .DEFAULT_UPPER(1024)
  ) dut (
    .SYS_aclk(clk),
    .SYS_aresetn(rstn),
    .S_AXIS_tvalid(tvalid),
    .S_AXIS_tdata(tdata),
    .CFG_start(start),
    .CFG_continuous(cont),
    .CFG_hyst_shift(shift),
    .CFG_min_span(min_span),
    .CFG_manual(manual),
    .CFG_manual_lower(man_lo),
    .CFG_manual_upper(man_hi),
    .FC_lower_treshold(fc_lo),
    .FC_upper_treshold(fc_hi),
    .CAL_busy(busy),
    .CAL_done(done),
    .CAL_valid(valid),
    .CAL_error(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference state: what the calibrator should hold after each window.
  logic signed [W-1:0] win [N];
  longint exp_lo = -1024, exp_hi = 1024;
  bit     exp_valid = 1'b0, exp_err = 1'b0;

  task automatic model(input int sh, input longint mspan);
    longint mn, mx, span, s, mid, delta;
    mn = win[0];
    mx = win[0];
    for (int i = 1; i < N; i++) begin
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
    end
    span  = mx - mn;
    s     = mn + mx;
    mid   = (s >= 0) ? s / 2 : -((-s + 1) / 2);
    delta = (span / 2) / (longint'(1) << sh);
    if (span >= mspan) begin
      exp_lo = mid - delta;
      exp_hi = mid + delta;
      exp_valid = 1'b1;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  function automatic logic signed [W-1:0] rnd();
    return W'($signed($urandom_range(2000, 0)) - 1000);
  endfunction

  // Feeds win[] as one window and checks the 2-cycle result latency and outputs.
  task automatic run_cal(input string tag, input int sh, input longint mspan, input bit gaps,
                         input bit use_start, input bit man);
    @(negedge clk);
    shift = 5'(sh);
    min_span = W'(mspan);
    if (use_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy after start"}, busy, 1);
    end
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        tvalid = 1'b0;
        tdata  = rnd();
        @(negedge clk);
      end
      tvalid = 1'b1;
      tdata  = win[i];
      if (i == 2) cont = 1'b0;
      if (man && i == 3) begin
        manual = 1'b1;
        man_lo = -3;
        man_hi = 3;
      end
      @(negedge clk);
      if (man && i == 3) begin
        chk({tag, " manual lower"}, fc_lo, -3);
        chk({tag, " manual upper"}, fc_hi, 3);
      end
    end
    tvalid = 1'b0;
    model(sh, mspan);
    chk({tag, " done k"}, done, 0);
    @(negedge clk);
    chk({tag, " done k+1"}, done, 0);
    @(negedge clk);
    chk({tag, " done k+2"}, done, 1);
    chk({tag, " lower"}, fc_lo, man ? -3 : exp_lo);
    chk({tag, " upper"}, fc_hi, man ? 3 : exp_hi);
    chk({tag, " valid"}, valid, exp_valid);
    chk({tag, " error"}, err, exp_err);
    manual = 1'b0;
    @(negedge clk);
    chk({tag, " done k+3"}, done, 0);
    chk({tag, " busy k+3"}, busy, 0);
    if (man) begin
      chk({tag, " cal lower after manual"}, fc_lo, exp_lo);
      chk({tag, " cal upper after manual"}, fc_hi, exp_hi);
    end
  endtask

  typedef struct {
    int s[N];
    int sh;
    int mspan;
    bit gaps;
    int lo;
    int hi;
    bit e;
  } vec_t;

  vec_t tbl[3];
  logic signed [W-1:0] stream [30];
  int dcount;

  initial begin
    tbl[0] = '{s: '{10, 5, 0, -5, -10, -15, 15, 0}, sh: 1, mspan: 4, gaps: 0, lo: -7, hi: 7, e: 0};
    tbl[1] = '{s: '{5, 5, 5, 5, 5, 5, 5, 5}, sh: 1, mspan: 4, gaps: 0, lo: -7, hi: 7, e: 1};
    tbl[2] = '{s: '{100, 110, 120, 130, 140, 125, 115, 105}, sh: 0, mspan: 4, gaps: 1,
               lo: 100, hi: 140, e: 0};

    // Reset held, then released.
    repeat (2) @(negedge clk);
    chk("reset lower held", fc_lo, -1024);
    chk("reset upper held", fc_hi, 1024);
    chk("reset busy held", busy, 0);
    chk("reset done held", done, 0);
    chk("reset valid held", valid, 0);
    chk("reset error held", err, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset lower released", fc_lo, -1024);
    chk("reset upper released", fc_hi, 1024);
    chk("reset busy released", busy, 0);
    chk("reset valid released", valid, 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) win[i] = tbl[t].s[i];
      run_cal($sformatf("tbl%0d", t), tbl[t].sh, tbl[t].mspan, tbl[t].gaps, 1'b1, 1'b0);
      chk($sformatf("tbl%0d table lower", t), fc_lo, tbl[t].lo);
      chk($sformatf("tbl%0d table upper", t), fc_hi, tbl[t].hi);
      chk($sformatf("tbl%0d table error", t), err, tbl[t].e);
      chk($sformatf("tbl%0d table valid", t), valid, 1);
    end

    for (int i = 0; i < N; i++) win[i] = rnd();
    run_cal("manual", 1, 10, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) win[i] = rnd();
      run_cal($sformatf("rand%0d", r), int'($urandom_range(4, 0)),
              longint'($urandom_range(1500, 0)), 1'b1, 1'b1, 1'b0);
    end

    // Continuous mode, async reset mid-window, start pulse while busy.
    @(negedge clk);
    cont = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1;
      tdata = rnd();
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    tvalid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async reset lower", fc_lo, -1024);
    chk("async reset upper", fc_hi, 1024);
    chk("async reset valid", valid, 0);
    chk("async reset busy", busy, 0);
    exp_lo = -1024;
    exp_hi = 1024;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    shift = 5'd2;
    min_span = W'(100);
    @(negedge clk);
    chk("continuous rearm busy", busy, 1);

    // Back-to-back windows: 8 counted, 2 skipped, with a stray start mid-window.
    dcount = 0;
    for (int j = 0; j < 30; j++) begin
      tvalid = 1'b1;
      tdata = rnd();
      stream[j] = tdata;
      start = (j == 13);
      @(negedge clk);
      if (done) begin
        for (int i = 0; i < N; i++) win[i] = stream[10 * dcount + i];
        model(2, 100);
        chk("b2b done position", j, 10 * dcount + 9);
        chk("b2b lower", fc_lo, exp_lo);
        chk("b2b upper", fc_hi, exp_hi);
        chk("b2b error", err, exp_err);
        dcount++;
      end
    end
    start = 1'b0;
    tvalid = 1'b0;
    chk("b2b done count", dcount, 3);

    // Continuous dropped mid-window: finish this window, then idle.
    for (int i = 0; i < N; i++) win[i] = rnd();
    run_cal("cont drop", 2, 100, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle after cont drop", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
